// File: rtl/toggle_event_rx_if.sv
// Event-side bundle of toggle_event_rx: decoded level, strobe, valid/ready
// event flag, running count and the sticky overrun flag with its clear.
interface toggle_event_rx_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 level;
  logic                 event_pulse;
  logic                 event_valid;
  logic                 event_ready;
  logic [CNT_WIDTH-1:0] event_count;
  logic                 overrun;
  logic                 clear_overrun;

  modport master (
    output level, event_pulse, event_valid, event_count, overrun,
    input  event_ready, clear_overrun
  );

  modport slave (
    input  level, event_pulse, event_valid, event_count, overrun,
    output event_ready, clear_overrun
  );
endinterface

// File: rtl/toggle_event_rx.sv
// Receive-side decoder for a remote TFF toggle line: synchronises T_in, turns
// every level change into a pulse, a valid/ready event, and a count.
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  Clk,
  input  logic                  asynch_reset_n,
  input  logic                  T_in,
  toggle_event_rx_if.master     ev
);

  typedef enum logic {IDLE, PENDING} state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   pulse_reg;
  logic [CNT_WIDTH-1:0]   count_reg;
  state_t                 state_reg;
  logic                   valid_reg;
  logic                   overrun_reg;
  logic                   level;
  logic                   change;
  logic                   overrun_set;

  assign level  = sync_reg[SYNC_STAGES-1];
  assign change = level ^ prev_reg;

  // A toggle landing on an unconsumed event merges into it and marks the loss.
  assign overrun_set = (state_reg == PENDING) && !ev.event_ready && change;

  always_ff @(posedge Clk or negedge asynch_reset_n) begin
    if (!asynch_reset_n) begin
      sync_reg  <= '0;
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], T_in};
      prev_reg  <= level;
      pulse_reg <= change;
      if (change) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge asynch_reset_n) begin
    if (!asynch_reset_n) begin
      state_reg   <= IDLE;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (change) begin
            state_reg <= PENDING;
            valid_reg <= 1'b1;
          end
        end
        PENDING: begin
          // Accept with a simultaneous new change keeps the event pending.
          if (ev.event_ready && !change) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase

      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (ev.clear_overrun) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign ev.level       = level;
  assign ev.event_pulse = pulse_reg;
  assign ev.event_valid = valid_reg;
  assign ev.event_count = count_reg;
  assign ev.overrun     = overrun_reg;

endmodule
